// File: rtl/spi_device_regbridge_if.sv
// rtl/spi_device_regbridge_if.sv - SPI device pins and register strobe bundle for spi_device_regbridge
interface spi_device_regbridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  busy;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, rd_data,
        output spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, rd_data,
        input  spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );
endinterface

// File: rtl/spi_device_regbridge.sv
// rtl/spi_device_regbridge.sv - oversampled SPI mode-0 device to register strobe bridge
// Optional address auto-increment: SPI_DEVICE_REGBRIDGE_AUTOINC_EN
module spi_device_regbridge #(
    parameter int ADDR_WIDTH  = 8,
    parameter int RD_LATENCY  = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    spi_device_regbridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DUMMY, WDATA, RDATA, DISCARD} state_t;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic                    sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d, cs_seen_q, cs_seen_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_in_q, shift_in_d, miso_shift_q, miso_shift_d, hold_q, hold_d;
    logic                    is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

    logic                  sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall, byte_done;
    logic [7:0]            byte_in;
    logic [ADDR_WIDTH-1:0] byte_addr;

    function automatic logic [ADDR_WIDTH-1:0] inc_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef SPI_DEVICE_REGBRIDGE_AUTOINC_EN
        return a + ADDR_WIDTH'(1);
`else
        return a;
`endif
    endfunction

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign byte_in   = {shift_in_q[6:0], mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign byte_addr = ADDR_WIDTH'(byte_in);

    always_comb begin
        state_d      = state_q;
        sck_sync_d   = SYNC_STAGES'({sck_sync_q, bus.spi_sck});
        cs_sync_d    = SYNC_STAGES'({cs_sync_q, bus.spi_cs_n});
        mosi_sync_d  = SYNC_STAGES'({mosi_sync_q, bus.spi_mosi});
        sck_prev_d   = sck_s;
        cs_prev_d    = cs_s;
        cs_seen_d    = cs_seen_q | cs_s;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        miso_shift_d = miso_shift_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        rd_pipe_d    = RD_LATENCY'({rd_pipe_q, rd_en_q});
        hold_d       = rd_pipe_q[RD_LATENCY-1] ? bus.rd_data : hold_q;

        if (state_q == IDLE) begin
            bit_cnt_d    = 3'd0;
            shift_in_d   = 8'h00;
            miso_shift_d = 8'h00;
            if (cs_fall) state_d = OPCODE;
        end else if (cs_s) begin
            // CS release wins over a coincident SCK edge, so a byte finishing here is dropped
            state_d = IDLE;
        end else begin
            if (sck_rise) begin
                shift_in_d = byte_in;
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                case (state_q)
                    OPCODE: begin
                        if (byte_in == OP_WRITE || byte_in == OP_READ) begin
                            state_d   = ADDR;
                            is_read_d = (byte_in == OP_READ);
                        end else begin
                            state_d = DISCARD;
                        end
                    end
                    ADDR: begin
                        addr_d = byte_addr;
                        if (is_read_q) begin
                            state_d   = DUMMY;
                            rd_en_d   = 1'b1;
                            rd_addr_d = byte_addr;
                            addr_d    = inc_addr(byte_addr);
                        end else begin
                            state_d = WDATA;
                        end
                    end
                    DUMMY:   state_d = RDATA;
                    WDATA: begin
                        wr_en_d   = 1'b1;
                        wr_data_d = byte_in;
                        wr_addr_d = addr_q;
                        addr_d    = inc_addr(addr_q);
                    end
                    default: ;
                endcase
            end
            // Fall after a byte boundary hands the prefetched byte to MISO and requests the next one
            if (sck_fall && state_q == RDATA) begin
                if (bit_cnt_q == 3'd0) begin
                    miso_shift_d = hold_q;
                    rd_en_d      = 1'b1;
                    rd_addr_d    = addr_q;
                    addr_d       = inc_addr(addr_q);
                end else begin
                    miso_shift_d = {miso_shift_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            cs_seen_q    <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_in_q   <= 8'h00;
            miso_shift_q <= 8'h00;
            hold_q       <= 8'h00;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'h00;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            cs_seen_q    <= cs_seen_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            miso_shift_q <= miso_shift_d;
            hold_q       <= hold_d;
            is_read_q    <= is_read_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    // OE stays low after reset until CS has been seen high, so a frame cut by reset stays silent
    assign bus.spi_miso    = (state_q == RDATA) & miso_shift_q[7];
    assign bus.spi_miso_oe = ~cs_s & cs_seen_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_device_regbridge.sv
// tb/tb_spi_device_regbridge.sv - directed SPI host bench with frame-level expectation model
module tb_spi_device_regbridge;
    localparam int AW = 8;
    localparam int H  = 8;
`ifdef SPI_DEVICE_REGBRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_device_regbridge_if #(.ADDR_WIDTH(AW)) bus ();

    spi_device_regbridge #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file stand-in: returns addr^0xFF exactly two cycles after rd_en, zero otherwise
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [AW-1:0] p1_a = '0, p2_a = '0;
    always @(posedge clk) begin
        p1_v <= bus.rd_en;
        p1_a <= bus.rd_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign bus.rd_data = p2_v ? (p2_a ^ 8'hFF) : 8'h00;

    int         n_checks = 0;
    int         n_errs   = 0;
    int         wr_cnt   = 0;
    int         rd_cnt   = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    bit         miso_zero_req = 1'b1;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  miso_seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   bus.wr_en, 0);
        check({tag, "_rd_en"},   bus.rd_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_busy"},    bus.busy, 0);
        check({tag, "_miso"},    bus.spi_miso, 0);
        check({tag, "_miso_oe"}, bus.spi_miso_oe, 0);
    endtask

    // Strobe scoreboard: every rd_en/wr_en pulse must match the next expected transfer
    initial begin
        logic [15:0] e;
        logic [7:0]  ra;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.wr_en) begin
                    wr_cnt++;
                    last_wr_addr = bus.wr_addr;
                    last_wr_data = bus.wr_data;
                    if (exp_wr.size() == 0) check("wr_en_unexpected", bus.wr_en, 0);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", bus.wr_addr, e[15:8]);
                        check("wr_data", bus.wr_data, e[7:0]);
                    end
                end
                if (bus.rd_en) begin
                    rd_cnt++;
                    if (exp_rd.size() == 0) check("rd_en_unexpected", bus.rd_en, 0);
                    else begin
                        ra = exp_rd.pop_front();
                        check("rd_addr", bus.rd_addr, ra);
                    end
                end
                if (miso_zero_req) check("miso_zero", bus.spi_miso, 0);
            end
        end
    end

    // One host frame. The final SCK fall happens after CS rises, except where noted.
    task automatic run_frame(input logic [7:0] b0, b1, b2, b3, b4, input int nbits,
                             input bit cs_with_last, input int rst_at_bit, input string tag);
        logic [7:0] b[0:4];
        logic [7:0] reads[$];
        logic [7:0] a, cur, got;
        int eff, nfull;
        bit last_fall_seen;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        eff = cs_with_last ? nbits - 1 : nbits;
        if (rst_at_bit >= 0) eff = rst_at_bit;
        nfull = eff / 8;
        last_fall_seen = (rst_at_bit >= 0) || cs_with_last || (eff % 8 != 0);
        got = 8'h00;
        miso_seen.delete();
        if (nfull >= 2) begin
            a = b[1];
            if (b[0] == 8'h01) begin
                for (int j = 2; j < nfull; j++) begin
                    exp_wr.push_back({a, b[j]});
                    if (AUTOINC) a = a + 8'd1;
                end
            end else if (b[0] == 8'h02) begin
                reads.push_back(a);
                exp_rd.push_back(a);
                for (int j = 2; j < nfull; j++) begin
                    if (j < nfull - 1 || last_fall_seen) begin
                        if (AUTOINC) a = a + 8'd1;
                        reads.push_back(a);
                        exp_rd.push_back(a);
                    end
                end
            end
        end
        miso_zero_req = (b[0] != 8'h02);

        bus.spi_cs_n = 1'b0;
        wait_clk(H);
        check({tag, "_busy_mid"}, bus.busy, 1);
        check({tag, "_oe_mid"}, bus.spi_miso_oe, 1);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at_bit) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                check_all_zero({tag, "_post_rst"});
                miso_zero_req = 1'b1;
            end
            cur = b[i / 8];
            bus.spi_mosi = cur[7 - (i % 8)];
            wait_clk(H);
            got = {got[6:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            if (i == nbits - 1) begin
                if (cs_with_last) bus.spi_cs_n = 1'b1;
                wait_clk(H);
                bus.spi_cs_n = 1'b1;
                wait_clk(H);
                bus.spi_sck = 1'b0;
            end else begin
                wait_clk(H);
                bus.spi_sck = 1'b0;
            end
            if (b[0] == 8'h02 && rst_at_bit < 0 && i % 8 == 7 && i / 8 >= 3 && i / 8 < nfull) begin
                miso_seen.push_back(got);
                check({tag, "_miso_byte"}, got, reads[i / 8 - 3] ^ 8'hFF);
            end
        end
        wait_clk(H);
        check({tag, "_busy_end"}, bus.busy, 0);
        check({tag, "_oe_end"}, bus.spi_miso_oe, 0);
        check({tag, "_wr_missing"}, exp_wr.size(), 0);
        check({tag, "_rd_missing"}, exp_rd.size(), 0);
        exp_wr.delete();
        exp_rd.delete();
        miso_zero_req = 1'b1;
        wait_clk(H);
    endtask

    initial begin
        int w0, r0;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        rst = 1'b1;
        wait_clk(4);
        check_all_zero("reset");
        rst = 1'b0;
        wait_clk(10);

        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(8'h01, 8'h10, 8'hA5, 8'h00, 8'h00, 24, 1'b0, -1, "write");
        check("write_count", wr_cnt - w0, 1);
        check("write_addr_lit", last_wr_addr, 8'h10);
        check("write_data_lit", last_wr_data, 8'hA5);
        check("write_no_rd", rd_cnt - r0, 0);

        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 40, 1'b0, -1, "read");
        check("read_rd_count", rd_cnt - r0, 3);
        check("read_no_wr", wr_cnt - w0, 0);
        check("read_byte3_lit", miso_seen.size() > 0 ? miso_seen[0] : 8'hxx, 8'hDF);
        check("read_byte4_lit", miso_seen.size() > 1 ? miso_seen[1] : 8'hxx, AUTOINC ? 8'hDE : 8'hDF);

        w0 = wr_cnt;
        run_frame(8'h01, 8'hFF, 8'h11, 8'h22, 8'h00, 32, 1'b0, -1, "burst");
        check("burst_count", wr_cnt - w0, 2);
        check("burst_last_addr_lit", last_wr_addr, AUTOINC ? 8'h00 : 8'hFF);
        check("burst_last_data_lit", last_wr_data, 8'h22);

        w0 = wr_cnt;
        run_frame(8'h01, 8'h30, 8'hA8, 8'h00, 8'h00, 21, 1'b0, -1, "abort");
        run_frame(8'h01, 8'h31, 8'h77, 8'h00, 8'h00, 24, 1'b0, -1, "after_abort");
        check("abort_count", wr_cnt - w0, 1);
        check("abort_addr_lit", last_wr_addr, 8'h31);
        check("abort_data_lit", last_wr_data, 8'h77);

        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(8'h7E, 8'h10, 8'h55, 8'h00, 8'h00, 24, 1'b0, -1, "badop");
        check("badop_wr", wr_cnt - w0, 0);
        check("badop_rd", rd_cnt - r0, 0);

        w0 = wr_cnt;
        run_frame(8'h01, 8'h50, 8'h66, 8'h00, 8'h00, 24, 1'b1, -1, "cs_on_8th");
        check("cs_on_8th_wr", wr_cnt - w0, 0);

        w0 = wr_cnt; r0 = rd_cnt;
        run_frame(8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 32, 1'b0, 19, "rst_dummy");
        check("rst_dummy_rd", rd_cnt - r0, 1);
        check("rst_dummy_wr", wr_cnt - w0, 0);
        run_frame(8'h01, 8'h40, 8'h99, 8'h00, 8'h00, 24, 1'b0, -1, "after_rst");
        check("after_rst_count", wr_cnt - w0, 1);
        check("after_rst_addr_lit", last_wr_addr, 8'h40);
        check("after_rst_data_lit", last_wr_data, 8'h99);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
